// File: rtl/dcache_blocking_mem.sv
// -----------------------------------------------------------------------------
// dcache_blocking_mem
// Backing-memory responder that sits directly below the blocking D$. Evicted
// lines arrive as a writeback request followed by LINE_BEATS data beats and are
// stored in an internal line array. Fill requests are queued in a 2-entry FIFO,
// held back while a writeback is still streaming in, and returned as a
// LINE_BEATS-beat burst FILL_LAT cycles after they leave the FIFO.
//
// Ports
//   clk                      clock, all state on the rising edge
//   rst                      asynchronous reset, active low
//   dcache__mem_valid_r      request strobe (one cycle per request)
//   dcache__mem_wrbk_r       1 = writeback request, 0 = fill request
//   dcache__mem_addr_r       line address of the request
//   dcache__mem_dat_valid_r  writeback beat strobe
//   dcache__mem_sop_r        first writeback beat marker
//   dcache__mem_eop_r        last writeback beat marker
//   dcache__mem_dat_r        writeback beat data
//   mem__dcache_valid_w      fill beat valid (registered)
//   mem__dcache_sop_w        first fill beat marker
//   mem__dcache_eop_w        last fill beat marker
//   mem__dcache_data_w       fill beat data
//   mem__err_r               sticky protocol-error flag
// -----------------------------------------------------------------------------
module dcache_blocking_mem #(
  parameter int ADDR_W     = 32,
  parameter int BEAT_W     = 128,
  parameter int LINE_BEATS = 4,
  parameter int MEM_LINES  = 256,
  parameter int FILL_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dcache__mem_valid_r,
  input  logic              dcache__mem_wrbk_r,
  input  logic [ADDR_W-1:0] dcache__mem_addr_r,
  input  logic              dcache__mem_dat_valid_r,
  input  logic              dcache__mem_sop_r,
  input  logic              dcache__mem_eop_r,
  input  logic [BEAT_W-1:0] dcache__mem_dat_r,
  output logic              mem__dcache_valid_w,
  output logic              mem__dcache_sop_w,
  output logic              mem__dcache_eop_w,
  output logic [BEAT_W-1:0] mem__dcache_data_w,
  output logic              mem__err_r
);

  localparam int OFS    = $clog2(LINE_BEATS * BEAT_W / 8);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int BCNT_W = $clog2(LINE_BEATS);
  localparam int LAT_W  = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(LINE_BEATS - 1);
  localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(FILL_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_e;

  // Request decode
  logic [IDX_W-1:0] req_idx;
  logic             wb_req;
  logic             fill_req;
  logic             unused_addr_bits;

  assign req_idx  = dcache__mem_addr_r[OFS +: IDX_W];
  assign wb_req   = dcache__mem_valid_r &  dcache__mem_wrbk_r;
  assign fill_req = dcache__mem_valid_r & ~dcache__mem_wrbk_r;
  assign unused_addr_bits = ^{dcache__mem_addr_r[ADDR_W-1:OFS+IDX_W],
                              dcache__mem_addr_r[OFS-1:0]};

  // State
  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;

  logic              wb_pend_q, wb_pend_d;
  logic [IDX_W-1:0]  wb_idx_q, wb_idx_d;
  logic [BCNT_W-1:0] wb_cnt_q, wb_cnt_d;

  logic [IDX_W-1:0]  fifo_mem_q [2];
  logic [IDX_W-1:0]  fifo_mem_d [2];
  logic              fifo_wr_q, fifo_wr_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [BEAT_W-1:0] out_data_q, out_data_d;
  logic              err_q, err_d;

  logic [BEAT_W-1:0] line_mem [MEM_LINES][LINE_BEATS];

  logic fifo_full;
  logic fifo_push;
  logic fifo_pop;
  logic beat_wr;

  assign fifo_full = (fifo_cnt_q == 2'd2);
  assign fifo_push = fill_req & ~fifo_full;
  // Fills never leave the FIFO while a writeback is incomplete, so a fill that
  // follows a writeback to the same line always sees the new line.
  assign fifo_pop  = (state_q == ST_IDLE) && (fifo_cnt_q != 2'd0) && !wb_pend_q;
  assign beat_wr   = dcache__mem_dat_valid_r & wb_pend_q;

  // Writeback tracking; the line ends on the last beat or on an early eop.
  always_comb begin
    wb_pend_d = wb_pend_q;
    wb_idx_d  = wb_idx_q;
    wb_cnt_d  = wb_cnt_q;
    if (beat_wr) begin
      wb_cnt_d = wb_cnt_q + BCNT_W'(1);
      if (dcache__mem_eop_r || (wb_cnt_q == LAST_BEAT)) begin
        wb_pend_d = 1'b0;
        wb_cnt_d  = '0;
      end
    end
    if (wb_req && !wb_pend_q) begin
      wb_pend_d = 1'b1;
      wb_idx_d  = req_idx;
      wb_cnt_d  = '0;
    end
  end

  // Fill FIFO
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push) begin
      fifo_mem_d[fifo_wr_q] = req_idx;
      fifo_wr_d             = ~fifo_wr_q;
    end
    if (fifo_pop) begin
      fifo_rd_d = ~fifo_rd_q;
    end
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Sticky error: dropped fill, nested writeback, stray beat, bad sop/eop.
  always_comb begin
    err_d = err_q
          | (fill_req & fifo_full)
          | (wb_req & wb_pend_q)
          | (dcache__mem_dat_valid_r & ~wb_pend_q)
          | (beat_wr & (dcache__mem_sop_r != (wb_cnt_q == '0)))
          | (beat_wr & (dcache__mem_eop_r != (wb_cnt_q == LAST_BEAT)));
  end

  // FSM next state. Beat 0 is launched on the WAIT->DATA edge, so in DATA
  // beat_cnt holds the index of the beat launched on the coming edge.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    beat_cnt_d = beat_cnt_q;
    fill_idx_d = fill_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          state_d    = ST_WAIT;
          lat_cnt_d  = LAT_INIT;
          fill_idx_d = fifo_mem_q[fifo_rd_q];
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d    = ST_DATA;
          beat_cnt_d = BCNT_W'(1);
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      ST_DATA: begin
        if (beat_cnt_q == LAST_BEAT) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: registered beat, with a same-cycle writeback beat forwarded.
  always_comb begin
    logic              emit;
    logic [BCNT_W-1:0] rd_beat;
    logic [BEAT_W-1:0] rd_data;
    emit    = (state_q == ST_DATA) || ((state_q == ST_WAIT) && (lat_cnt_q == '0));
    rd_beat = (state_q == ST_DATA) ? beat_cnt_q : '0;
    rd_data = line_mem[fill_idx_q][rd_beat];
    if (beat_wr && (wb_idx_q == fill_idx_q) && (wb_cnt_q == rd_beat)) begin
      rd_data = dcache__mem_dat_r;
    end
    out_valid_d = emit;
    out_sop_d   = emit && (rd_beat == '0);
    out_eop_d   = emit && (rd_beat == LAST_BEAT);
    out_data_d  = emit ? rd_data : '0;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      beat_cnt_q <= '0;
      fill_idx_q <= '0;
      wb_pend_q  <= 1'b0;
      wb_idx_q   <= '0;
      wb_cnt_q   <= '0;
      fifo_mem_q <= '{default: '0};
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      fill_idx_q <= fill_idx_d;
      wb_pend_q  <= wb_pend_d;
      wb_idx_q   <= wb_idx_d;
      wb_cnt_q   <= wb_cnt_d;
      fifo_mem_q <= fifo_mem_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_valid_q <= out_valid_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  // Line array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (beat_wr) begin
      line_mem[wb_idx_q][wb_cnt_q] <= dcache__mem_dat_r;
    end
  end

  assign mem__dcache_valid_w = out_valid_q;
  assign mem__dcache_sop_w   = out_sop_q;
  assign mem__dcache_eop_w   = out_eop_q;
  assign mem__dcache_data_w  = out_data_q;
  assign mem__err_r          = err_q;

endmodule
